mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Shares one booth_mult instance between NREQ requesters, e.g. the rotation transform, a gyro scaler and an odometry block.
- Arbitrates requests, latches the winner's operands, and drives the en/busy handshake to the multiplier.
- Returns the 32-bit product with a one-cycle done pulse to the winning requester.
- Lives in T_Rot, between the compute FSMs and the single multiplier.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand width; product width is 2*W.
- IDW, 3, width of the grant index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request, level.
- a_in  in  NREQ*W  packed operand A; slice i belongs to requester i.
- b_in  in  NREQ*W  packed operand B; slice i belongs to requester i.
- done  out  NREQ  one-cycle pulse to the requester whose product is valid.
- result  out  2*W  product; held until the next capture.
- gnt_id  out  IDW  index of the current or last owner.
- arb_busy  out  1  high while an operation is in flight.
- m_en  out  1  to booth_mult en.
- m_a  out  W  to booth_mult A (registered).
- m_b  out  W  to booth_mult B (registered).
- m_r  in  2*W  from booth_mult R.
- m_busy  in  1  from booth_mult busy.

Behaviour:
- Reset values: done=0, result=0, gnt_id=0, arb_busy=0, m_en=0, m_a=0, m_b=0, state=IDLE, rr pointer=0.
- All outputs are registered; no combinational path from req to any output.
- IDLE:
  - If any req bit is set: pick a winner, latch gnt_id, m_a and m_b from that requester's slices, set m_en=1 and arb_busy=1, go to START.
  - Otherwise stay in IDLE.
- START:
  - Hold m_en=1 until m_busy=1 is sampled.
  - Then set m_en=0 and go to RUN.
- RUN:
  - Hold m_en=0 while m_busy=1.
  - On the first sample of m_busy=0, capture result<=m_r, set done[gnt_id]=1, go to DONE.
- DONE:
  - done returns to 0; arb_busy=0; return to IDLE.
  - A new grant can be issued in the cycle after DONE.
  - Minimum gap between consecutive grants is therefore 1 idle cycle.
- Operand capture: operands are latched at grant. Requester inputs may change after grant without affecting the operation in flight.
- Request protocol: a requester holds req until it sees its done pulse.
  - Deasserting req mid-operation does not abort the operation; done still pulses to that requester.
  - A req still high in the cycle after done counts as a new request.
- Simultaneous requests: exactly one grant per arbitration. Losers wait with no timeout; they are never dropped.
- Product arithmetic: the product is passed through unmodified from booth_mult (two's-complement signed). No shift or rounding is applied here.
- Reset mid-operation:
  - Everything returns to reset values and no done is issued.
  - Requesters must re-request; booth_mult is reset by the same rst.
- m_busy=1 while in IDLE (multiplier state inconsistent): ignored. The next START waits for a clean busy rise, so no spurious done is produced.
- Contract: exactly one done pulse per grant, at most one done bit set per cycle.

Optional Feature:
- Macro: MULT_SHARE_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at rr_ptr, wrapping modulo NREQ.
  - After each grant, rr_ptr <= gnt_id+1, wrapping from NREQ-1 to 0.
  - Guarantees each requester is served within NREQ grants.
- Undefined: fixed priority, lowest index wins; the rr_ptr register is not built.

Decomposition:
- Package mult_share_pkg:
  - localparams for the state encoding (IDLE=0, START=1, RUN=2, DONE=3).
  - Default W, NREQ, IDW values.
- Sub-module mult_share_pick (combinational picker):
  - Inputs: req and rr_ptr.
  - Outputs: valid and index.
  - Contains the rotate, priority-encode and unrotate logic.
- The picker is instantiated once; the FSM and registers stay in the top.

Test Plan:
- Bench multiplier model raises busy 1 cycle after en and keeps busy high for 17 cycles.
- Single request: req=0001, a0=3, b0=-5 -> m_en high until busy; done=0001 exactly once; result=32'hFFFFFFF1; gnt_id=0.
- Contention: req=1111 held, operands i*100 x 2 for each i.
  - With MULT_SHARE_RR_EN: grant order 0,1,2,3,0...
  - Without it: requester 0 is granted repeatedly.
  - Each result matches its requester's product.
- Operand change after grant: a1 changes from 7 to 9 one cycle after gnt_id=1 (b1=2) -> result=14, not 18.
- Early release: req[2] drops during RUN -> done[2] still pulses once; no regrant to 2 afterwards.
- Reset mid-RUN: assert rst for 1 cycle at busy cycle 8 -> all outputs 0, no done; the pending req=0010 is then granted and completes normally.
- Back-to-back: req=0001 held continuously -> consecutive done pulses separated by START+RUN+DONE+1 cycles; m_en never high during RUN.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// State encoding and default NREQ/W/IDW used by the top, picker and interface.
package mult_share_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 16;
  localparam int IDW_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    RUN   = ST_RUN,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side and booth_mult-side signals of the shared multiplier arbiter.
// slave = arbiter view, master = environment (requesters + multiplier) view.
interface mult_share_arbiter_if
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    result;
  logic [IDW-1:0]    gnt_id;
  logic              arb_busy;
  logic              m_en;
  logic [W-1:0]      m_a;
  logic [W-1:0]      m_b;
  logic [2*W-1:0]    m_r;
  logic              m_busy;

  modport slave (
    input  req, a_in, b_in, m_r, m_busy,
    output done, result, gnt_id, arb_busy, m_en, m_a, m_b
  );

  modport master (
    output req, a_in, b_in, m_r, m_busy,
    input  done, result, gnt_id, arb_busy, m_en, m_a, m_b
  );

endinterface

// File: rtl/mult_share_pick.sv
// Combinational request picker: rotate by rr pointer, lowest-index first, unrotate.
// Zero latency; a zero pointer degenerates to fixed lowest-index priority.
module mult_share_pick
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_rr_ptr,
  output logic            o_vld,
  output logic [IDW-1:0]  o_idx
);

  logic [NREQ-1:0] w_rot;

  always_comb begin
    w_rot = '0;
    o_vld = 1'b0;
    o_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_rot[k] = i_req[(k + int'(i_rr_ptr)) % NREQ];
    end
    // Descending scan so the lowest rotated position is the last writer.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_vld = 1'b1;
        o_idx = IDW'((k + int'(i_rr_ptr)) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one booth_mult between NREQ requesters; grant -> START -> RUN -> DONE, all outputs registered.
// Losers wait indefinitely; round-robin when MULT_SHARE_RR_EN is defined, else fixed lowest-index priority.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
) (
  input logic                clk,
  input logic                rst,
  mult_share_arbiter_if.slave bus
);

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_done, w_done_nxt;
  logic [2*W-1:0]   r_result, w_result_nxt;
  logic [IDW-1:0]   r_gnt_id, w_gnt_nxt;
  logic             r_arb_busy, w_abusy_nxt;
  logic             r_m_en, w_men_nxt;
  logic [W-1:0]     r_m_a, w_ma_nxt;
  logic [W-1:0]     r_m_b, w_mb_nxt;
  logic             r_busy_q;
  logic             w_pick_vld;
  logic [IDW-1:0]   w_pick_idx;
  logic [IDW-1:0]   w_rr_ptr;

`ifdef MULT_SHARE_RR_EN
  logic [IDW-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (r_state == IDLE && w_pick_vld) begin
      r_rr_ptr <= (w_pick_idx == IDW'(NREQ - 1)) ? '0 : w_pick_idx + IDW'(1);
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = '0;
`endif

  mult_share_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req    (bus.req),
    .i_rr_ptr (w_rr_ptr),
    .o_vld    (w_pick_vld),
    .o_idx    (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_done     <= '0;
      r_result   <= '0;
      r_gnt_id   <= '0;
      r_arb_busy <= 1'b0;
      r_m_en     <= 1'b0;
      r_m_a      <= '0;
      r_m_b      <= '0;
      r_busy_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_result   <= w_result_nxt;
      r_gnt_id   <= w_gnt_nxt;
      r_arb_busy <= w_abusy_nxt;
      r_m_en     <= w_men_nxt;
      r_m_a      <= w_ma_nxt;
      r_m_b      <= w_mb_nxt;
      r_busy_q   <= bus.m_busy;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_done_nxt   = '0;
    w_result_nxt = r_result;
    w_gnt_nxt    = r_gnt_id;
    w_abusy_nxt  = r_arb_busy;
    w_men_nxt    = r_m_en;
    w_ma_nxt     = r_m_a;
    w_mb_nxt     = r_m_b;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt   = w_pick_idx;
          w_ma_nxt    = bus.a_in[int'(w_pick_idx) * W +: W];
          w_mb_nxt    = bus.b_in[int'(w_pick_idx) * W +: W];
          w_men_nxt   = 1'b1;
          w_abusy_nxt = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        // Require a fresh busy rise so a stale busy level cannot fake an ack.
        if (bus.m_busy && !r_busy_q) begin
          w_men_nxt   = 1'b0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!bus.m_busy) begin
          w_result_nxt = bus.m_r;
          for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == r_gnt_id) w_done_nxt[k] = 1'b1;
          end
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_abusy_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.gnt_id   = r_gnt_id;
  assign bus.arb_busy = r_arb_busy;
  assign bus.m_en     = r_m_en;
  assign bus.m_a      = r_m_a;
  assign bus.m_b      = r_m_b;

endmodule
